// File: rtl/salsa20_keystream_ctrl.sv
// Salsa20 block sequencer and keystream XOR stage for a valid/ready byte stream.
// Define SALSA20_KEY128_EN to add the key128 input (16-byte key expansion).
module salsa20_keystream_ctrl #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [7:0]  key [0:31],
  input  logic [7:0]  nonce [0:7],
  input  logic [63:0] ctr_init,
`ifdef SALSA20_KEY128_EN
  input  logic        key128,
`endif
  output logic        hash_start,
  output logic [3:0]  hash_rounds,
  output logic [7:0]  hash_x [0:63],
  input  logic        hash_valid,
  input  logic [7:0]  hash_z [0:63],
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [7:0]  din,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [7:0]  dout,
  output logic [63:0] block_ctr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, STREAM} state_t;

  state_t      state, state_next;
  logic [7:0]  key_r [0:31];
  logic [7:0]  nonce_r [0:7];
  logic [7:0]  ks [0:63];
  logic [5:0]  idx;
  logic        accept;
  logic        last;
  logic        k16;
  logic [31:0] c0, c1, c2, c3;

`ifdef SALSA20_KEY128_EN
  logic key128_r;
  assign k16 = key128_r;
`else
  assign k16 = 1'b0;
`endif

  assign hash_rounds = 4'(DOUBLE_ROUNDS);
  assign hash_start  = (state == START);
  assign busy        = (state != IDLE);
  assign din_ready   = (state == STREAM) && (!dout_valid || dout_ready);
  assign accept      = din_valid && din_ready;
  assign last        = (idx == 6'd63);

  // Hash input block: 16 little-endian words built from the latched key material.
  always_comb begin
    c0 = 32'h61707865;
    c1 = k16 ? 32'h3120646e : 32'h3320646e;
    c2 = k16 ? 32'h79622d36 : 32'h79622d32;
    c3 = 32'h6b206574;
    for (int unsigned i = 0; i < 4; i++) begin
      hash_x[i]      = c0[8*i +: 8];
      hash_x[20 + i] = c1[8*i +: 8];
      hash_x[40 + i] = c2[8*i +: 8];
      hash_x[60 + i] = c3[8*i +: 8];
    end
    for (int unsigned i = 0; i < 16; i++) begin
      hash_x[4 + i]  = key_r[i];
      hash_x[44 + i] = k16 ? key_r[i] : key_r[16 + i];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      hash_x[24 + i] = nonce_r[i];
      hash_x[32 + i] = block_ctr[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      START:   state_next = WAIT;
      WAIT:    if (hash_valid) state_next = STREAM;
      STREAM:  if (accept && last) state_next = START;
      default: state_next = IDLE;
    endcase
    if (init) state_next = START;
  end

  // init outranks a same-cycle byte acceptance, so that beat is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      block_ctr  <= '0;
    end else if (init) begin
      key_r      <= key;
      nonce_r    <= nonce;
      block_ctr  <= ctr_init;
      idx        <= '0;
      dout_valid <= 1'b0;
`ifdef SALSA20_KEY128_EN
      key128_r   <= key128;
`endif
    end else begin
      if (state == WAIT && hash_valid) begin
        ks  <= hash_z;
        idx <= '0;
      end
      if (accept) begin
        dout       <= din ^ ks[idx];
        dout_valid <= 1'b1;
        idx        <= idx + 6'd1;
        if (last) block_ctr <= block_ctr + 64'd1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
